memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 32, is the number of VRAM words per video burst (one 512-pixel scanline).
REQ-002 Parameter MIN_GAP, default 2, is the minimum number of cycles mem_busy stays low between two video bursts.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_load  input  1  CPU write strobe.
REQ-006 mem_address  input  16  CPU word address.
REQ-007 mem_wdata  input  16  CPU write data.
REQ-008 mem_rdata  output  16  CPU read data, registered.
REQ-009 mem_busy  output  1  registered; high while video owns the VRAM port.
REQ-010 vid_req  input  1  one-cycle pulse requesting a burst.
REQ-011 vid_addr  input  13  VRAM start word of the burst, sampled on accept.
REQ-012 vid_rdata  output  16  video read data, registered.
REQ-013 vid_valid  output  1  high for one cycle per returned burst word.
REQ-014 keyboard  input  16  current key code.

Function
REQ-015 The address map SHALL be: 0x0000-0x3FFF RAM (16K x16, internal); 0x4000-0x5FFF VRAM (8K x16, internal, single port); 0x6000 keyboard (read-only); 0x6001-0xFFFF unmapped.
REQ-016 RAM, keyboard and unmapped reads SHALL appear on mem_rdata one cycle after the address is presented; unmapped reads SHALL return 0x0000.
REQ-017 A RAM write SHALL occur in the cycle mem_load is high, regardless of mem_busy.
REQ-018 Writes to the keyboard or unmapped addresses SHALL be ignored.
REQ-019 The VRAM port SHALL be owned by the CPU in every cycle where mem_busy is low; a VRAM write with mem_load high in such a cycle SHALL complete in that cycle.
REQ-020 A VRAM write with mem_load high while mem_busy is high SHALL be ignored; the CPU retries.
REQ-021 For a CPU VRAM read, mem_rdata SHALL load VRAM[mem_address-0x4000] on the edge after each CPU-owned cycle, and SHALL hold its value while mem_busy is high.
REQ-022 The state machine SHALL have three states: IDLE, BURST and GAP.
REQ-023 IDLE: vid_req high at cycle t SHALL latch vid_addr, set mem_busy=1 from t+1, and enter BURST.
REQ-024 BURST: in cycles t+1 through t+BURST_LEN, the arbiter SHALL issue one VRAM read per cycle at vid_addr+k, with 13-bit wrap (0x1FFF wraps to 0x0000).
REQ-025 Each read issued at cycle c SHALL return on vid_rdata with vid_valid=1 at c+1.
REQ-026 At cycle t+BURST_LEN+1 the arbiter SHALL drive mem_busy=0 and enter GAP.
REQ-027 GAP: mem_busy SHALL stay low for MIN_GAP cycles before returning to IDLE.
REQ-028 vid_req arriving in BURST or GAP SHALL be held pending and accepted on the first IDLE cycle; at most one request SHALL be pending, and further requests SHALL be dropped.
REQ-029 A CPU VRAM write in the same cycle that a vid_req is accepted SHALL complete, since mem_busy is still low in that cycle.
REQ-030 mem_busy SHALL come directly from a register, with no combinational path from any input.

Reset
REQ-031 reset SHALL force: state=IDLE, mem_busy=0, vid_valid=0, mem_rdata=0x0000, vid_rdata=0x0000, and the pending request cleared.
REQ-032 reset during BURST SHALL abort the burst; vid_valid SHALL be low from the cycle after reset is sampled.
REQ-033 RAM and VRAM contents SHALL NOT be affected by reset.

Verification
REQ-034 Write 0x1234 to 0x0010, then read 0x0010 -> mem_rdata=0x1234 one cycle after the read address is presented; read 0x6000 with keyboard=0x0041 -> 0x0041; read 0x7000 -> 0x0000.
REQ-035 vid_req at t with vid_addr=0x1FF0 -> mem_busy high t+1..t+32; vid_valid t+2..t+33; addresses 0x1FF0..0x1FFF then 0x0000..0x000F.
REQ-036 CPU VRAM write of 0xBEEF to 0x4005 in the same cycle as vid_req -> word stored; a second write attempted at t+1 (mem_busy=1) -> VRAM unchanged.
REQ-037 vid_req held high continuously -> mem_busy low for exactly MIN_GAP=2 cycles between bursts; a CPU VRAM read issued in the gap returns correct data, held stable through the next burst.
REQ-038 reset asserted at burst word 10 -> vid_valid=0 and mem_busy=0 on the next cycle, no further vid_valid pulses, and previously written RAM data still readable.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter
// CPU / video arbiter for a 16-bit memory map with internal RAM, a
// single-port VRAM and a keyboard register.
//
// The video side requests bursts of BURST_LEN consecutive VRAM words. While a
// burst runs, mem_busy is high and the VRAM port belongs to video. In every
// other cycle the port belongs to the CPU.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   mem_load     CPU write strobe
//   mem_address  CPU word address (RAM 0x0000-0x3FFF, VRAM 0x4000-0x5FFF,
//                keyboard 0x6000, everything else unmapped)
//   mem_wdata    CPU write data
//   mem_rdata    CPU read data, registered, one cycle after the address
//   mem_busy     registered, high while video owns the VRAM port
//   vid_req      burst request pulse
//   vid_addr     VRAM start word of a burst
//   vid_rdata    video read data, registered
//   vid_valid    high for one cycle per returned burst word
//   keyboard     current key code
module memory_arbiter #(
  parameter int BURST_LEN = 32,
  parameter int MIN_GAP   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_load,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_busy,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [15:0] vid_rdata,
  output logic        vid_valid,
  input  logic [15:0] keyboard
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   burst_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [12:0]     burst_addr_q;
  logic            pend_q;
  logic [12:0]     pend_addr_q;
  logic            mem_busy_q;
  logic            vid_valid_q;
  logic [15:0]     vid_rdata_q;
  logic [15:0]     mem_rdata_q;

  logic [15:0]     ram_q  [0:16383];
  logic [15:0]     vram_q [0:8191];

  logic            ram_sel_s;
  logic            vram_sel_s;
  logic            kbd_sel_s;
  logic            gap_last_s;
  logic            start_s;
  logic [12:0]     start_addr_s;
  logic            vram_we_s;
  logic [12:0]     vram_addr_s;

  // Address decode, burst start condition and the single VRAM port address.
  always_comb begin
    ram_sel_s    = (mem_address[15:14] == 2'b00);
    vram_sel_s   = (mem_address[15:13] == 3'b010);
    kbd_sel_s    = (mem_address == 16'h6000);
    gap_last_s   = (state_q == GAP) && (gap_cnt_q == GW'(MIN_GAP - 1));
    // The last GAP cycle doubles as the acceptance point so that back-to-back
    // bursts see exactly MIN_GAP low cycles of mem_busy.
    start_s      = ((state_q == IDLE) || gap_last_s) && (vid_req || pend_q);
    start_addr_s = pend_q ? pend_addr_q : vid_addr;
    vram_we_s    = mem_load && vram_sel_s && !mem_busy_q;
    vram_addr_s  = mem_busy_q ? burst_addr_q : mem_address[12:0];
  end

  // Burst state machine with the pending-request slot and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_busy_q   <= 1'b0;
      vid_valid_q  <= 1'b0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      burst_addr_q <= 13'h0000;
      pend_q       <= 1'b0;
      pend_addr_q  <= 13'h0000;
    end else begin
      vid_valid_q <= (state_q == BURST);

      // One pending slot: a request consuming the slot frees it for a new
      // request in the same cycle; anything beyond one is dropped.
      if (start_s) begin
        pend_q      <= pend_q && vid_req;
        pend_addr_q <= vid_addr;
      end else if ((state_q != IDLE) && vid_req && !pend_q) begin
        pend_q      <= 1'b1;
        pend_addr_q <= vid_addr;
      end

      if (start_s) begin
        state_q      <= BURST;
        mem_busy_q   <= 1'b1;
        burst_addr_q <= start_addr_s;
        burst_cnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          BURST: begin
            burst_addr_q <= burst_addr_q + 13'd1;
            if (burst_cnt_q == CW'(BURST_LEN - 1)) begin
              state_q    <= GAP;
              mem_busy_q <= 1'b0;
              gap_cnt_q  <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_q + CW'(1);
            end
          end
          GAP: begin
            if (gap_last_s) begin
              state_q <= IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GW'(1);
            end
          end
          default: begin
            state_q    <= IDLE;
            mem_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // RAM writes; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_load && ram_sel_s) begin
      ram_q[mem_address[13:0]] <= mem_wdata;
    end
  end

  // VRAM writes, only while the CPU owns the port.
  always_ff @(posedge clk) begin
    if (vram_we_s) begin
      vram_q[vram_addr_s] <= mem_wdata;
    end
  end

  // Video read data: one word per BURST cycle, visible the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_rdata_q <= 16'h0000;
    end else if (state_q == BURST) begin
      vid_rdata_q <= vram_q[vram_addr_s];
    end
  end

  // CPU read data; a VRAM read holds its last value while video owns the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata_q <= 16'h0000;
    end else if (ram_sel_s) begin
      mem_rdata_q <= ram_q[mem_address[13:0]];
    end else if (vram_sel_s) begin
      if (!mem_busy_q) begin
        mem_rdata_q <= vram_q[vram_addr_s];
      end
    end else if (kbd_sel_s) begin
      mem_rdata_q <= keyboard;
    end else begin
      mem_rdata_q <= 16'h0000;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign mem_busy  = mem_busy_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_valid = vid_valid_q;

endmodule
